// File: rtl/param_stack.sv
// param_stack: parametrised LIFO stack; TOS held in a register, lower entries in distributed RAM
module param_stack #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  input  logic                     err_clr,
  output logic [WIDTH-1:0]         tos,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_ram [DEPTH];
  logic [WIDTH-1:0] r_tos;
  logic [AW:0]      r_count;
  logic             r_ovf;
  logic             r_unf;
  logic [AW:0]      w_cm1;
  logic [AW:0]      w_cm2;
  logic [WIDTH-1:0] w_rd;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic             w_grow;
  logic             w_rep;
  assign empty     = r_count == '0;
  assign full      = r_count == (AW+1)'(DEPTH);
  assign w_cm1     = r_count - (AW+1)'(1);
  assign w_cm2     = r_count - (AW+1)'(2);
  assign w_push_ok = push & ~pop & ~full;
  assign w_pop_ok  = pop & ~push & ~empty;
  assign w_rep     = push & pop;
  // replace on an empty stack grows it exactly like a push
  assign w_grow    = w_push_ok | (w_rep & empty);
  assign w_rd      = r_ram[w_cm2[AW-1:0]];
  always_ff @(posedge clk)
    if (w_push_ok && !empty) r_ram[w_cm1[AW-1:0]] <= r_tos;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_tos   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      if (w_grow) begin
        r_tos   <= din;
        r_count <= r_count + (AW+1)'(1);
      end else if (w_rep) begin
        r_tos <= din;
      end else if (w_pop_ok) begin
        r_tos   <= (r_count == (AW+1)'(1)) ? '0 : w_rd;
        r_count <= w_cm1;
      end
      r_ovf <= (push & ~pop & full) | (r_ovf & ~err_clr);
      r_unf <= (pop & ~push & empty) | (r_unf & ~err_clr);
    end
  assign tos       = r_tos;
  assign count     = r_count;
  assign overflow  = r_ovf;
  assign underflow = r_unf;
endmodule

// File: tb/tb_param_stack.sv
// tb_param_stack: queue-based LIFO reference with per-cycle compare plus hand-computed checks
module tb_param_stack;
  localparam int W = 13;
  localparam int D = 16;
  logic clk = 0;
  logic reset = 1;
  logic push = 0;
  logic pop = 0;
  logic err_clr = 0;
  logic [W-1:0] din = '0;
  logic [W-1:0] tos;
  logic [4:0]   count;
  logic empty, full, overflow, underflow;
  int n_chk = 0;
  int n_pass = 0;
  int m_q[$];
  bit m_ovf = 0;
  bit m_unf = 0;

  param_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din), .err_clr(err_clr),
    .tos(tos), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
  endtask

  function automatic int m_tos();
    return m_q.size() == 0 ? 0 : m_q[$];
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic model_step(bit pu, bit po, int d, bit clr);
    bit eo = 0;
    bit eu = 0;
    if (pu && !po) begin
      if (m_q.size() == D) eo = 1;
      else m_q.push_back(d);
    end else if (po && !pu) begin
      if (m_q.size() == 0) eu = 1;
      else void'(m_q.pop_back());
    end else if (pu && po) begin
      if (m_q.size() == 0) m_q.push_back(d);
      else m_q[m_q.size()-1] = d;
    end
    m_ovf = eo | (m_ovf & ~clr);
    m_unf = eu | (m_unf & ~clr);
  endtask

  task automatic op(bit pu, bit po, int d, bit clr = 0);
    @(negedge clk);
    #1;
    push = pu; pop = po; din = W'(d); err_clr = clr;
    model_step(pu, po, d, clr);
    @(posedge clk);
    #1;
    push = 0; pop = 0; err_clr = 0;
  endtask

  always @(negedge clk) begin
    check("cmp_tos", int'(tos), m_tos());
    check("cmp_count", int'(count), m_q.size());
    check("cmp_empty", int'(empty), int'(m_q.size() == 0));
    check("cmp_full", int'(full), int'(m_q.size() == D));
    check("cmp_overflow", int'(overflow), int'(m_ovf));
    check("cmp_underflow", int'(underflow), int'(m_unf));
  end

  initial begin
    int prev;
    #1;
    check("rst_tos", int'(tos), 0);
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_flags", int'({overflow, underflow}), 0);
    @(negedge clk);
    #2 reset = 0;

    op(1, 0, 'h0A1); op(1, 0, 'h0B2); op(1, 0, 'h0C3);
    check("p3_count", int'(count), 3);
    check("p3_tos", int'(tos), 'h0C3);
    op(0, 1, 0); check("pop1_tos", int'(tos), 'h0B2);
    op(0, 1, 0); check("pop2_tos", int'(tos), 'h0A1);
    op(0, 1, 0); check("pop3_tos", int'(tos), 0);
    check("pop3_count", int'(count), 0);
    check("pop3_empty", int'(empty), 1);
    check("pop3_unf", int'(underflow), 0);

    for (int i = 1; i <= D; i++) op(1, 0, i);
    check("fill_full", int'(full), 1);
    check("fill_tos", int'(tos), D);
    op(1, 0, 'h1FFF);
    check("ovf_count", int'(count), D);
    check("ovf_tos", int'(tos), D);
    check("ovf_flag", int'(overflow), 1);
    for (int i = D - 1; i >= 0; i--) begin
      op(0, 1, 0);
      check("drain_tos", int'(tos), i);
    end
    op(0, 0, 0, 1);

    op(0, 1, 0);
    check("unf_flag", int'(underflow), 1);
    check("unf_count", int'(count), 0);
    check("unf_tos", int'(tos), 0);
    op(0, 1, 0, 1);
    check("unf_clr_race", int'(underflow), 1);
    op(0, 0, 0, 1);
    check("unf_cleared", int'(underflow), 0);

    op(1, 0, 5); op(1, 0, 6); op(1, 1, 9);
    check("rep_count", int'(count), 2);
    check("rep_tos", int'(tos), 9);
    op(0, 1, 0);
    check("rep_pop_tos", int'(tos), 5);
    op(0, 1, 0);
    op(1, 1, 7);
    check("rep_empty_count", int'(count), 1);
    check("rep_empty_tos", int'(tos), 7);
    check("rep_empty_err", int'({overflow, underflow}), 0);
    op(0, 1, 0);

    op(1, 0, $urandom_range(0, 8191));
    prev = m_q.size();
    for (int i = 0; i < 100; i++) begin
      op(1, 0, $urandom_range(0, 8191));
      check("alt_push_count", int'(count), prev + 1);
      op(0, 1, 0);
      check("alt_pop_count", int'(count), prev);
    end

    for (int i = 0; i < 600; i++) begin
      int r = $urandom_range(0, 9);
      op(r < 4 || r == 8, (r >= 4 && r < 8) || r == 8, $urandom_range(0, 8191), $urandom_range(0, 15) == 0);
    end

    op(0, 0, 0, 1);
    while (m_q.size() > 0) op(0, 1, 0);
    for (int i = 0; i < 4; i++) op(1, 0, 'h100 + i);
    #2;
    reset = 1;
    model_clear();
    #1;
    check("arst_tos", int'(tos), 0);
    check("arst_count", int'(count), 0);
    check("arst_empty", int'(empty), 1);
    check("arst_full", int'(full), 0);
    @(negedge clk);
    #2 reset = 0;
    op(0, 1, 0);
    check("arst_pop_unf", int'(underflow), 1);
    check("arst_pop_tos", int'(tos), 0);
    op(1, 0, 'h55);
    check("arst_push_tos", int'(tos), 'h55);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
